// File: rtl/bumpy_life_ctrl.sv
// Death/respawn sequencer for Bumpy: owns the life counter, times the dying and
// invulnerability windows, and drives the movement FSM's active-low reset.
//
//   state      | meaning
//   S_PLAY     | normal play, watching bumpy_state for the death code
//   S_DYING    | dying animation, DIE_FRAMES frames, sprite blinks
//   S_RESPAWN  | single cycle: movement FSM held in reset, start position reloaded
//   S_INVULN   | invulnerability, INVULN_FRAMES frames, deaths ignored, sprite blinks
//   S_GAMEOVER | no lives left, movement FSM frozen until new_game
module bumpy_life_ctrl #(
  parameter int unsigned INIT_LIVES    = 3,
  parameter int unsigned MAX_LIVES     = 7,
  parameter logic [3:0]  DIE_CODE      = 4'd6,
  parameter int unsigned DIE_FRAMES    = 60,
  parameter int unsigned INVULN_FRAMES = 120,
  parameter int unsigned BLINK_SHIFT   = 3
) (
  input  logic       clk,
  input  logic       resetN,
  input  logic       startOfFrame,
  input  logic [3:0] bumpy_state,
  input  logic       add_life,
  input  logic       new_game,
  output logic [2:0] lives,
  output logic       bumpy_fsm_resetN,
  output logic       respawn_pulse,
  output logic       blink,
  output logic       game_over,
  output logic [2:0] ctrl_state
);

  typedef enum logic [2:0] {
    S_PLAY     = 3'd0,
    S_DYING    = 3'd1,
    S_RESPAWN  = 3'd2,
    S_INVULN   = 3'd3,
    S_GAMEOVER = 3'd4
  } state_e;

  localparam logic [7:0] DIE_LAST    = 8'(DIE_FRAMES - 1);
  localparam logic [7:0] INVULN_LAST = 8'(INVULN_FRAMES - 1);
  localparam logic [3:0] LIVES_INIT  = 4'(INIT_LIVES);
  localparam logic [3:0] LIVES_MAX   = 4'(MAX_LIVES);

  state_e     state_q, state_d;
  logic [2:0] lives_q, lives_d;
  logic [7:0] frame_cnt_q, frame_cnt_d;

  logic       death;
  logic       frame_last;
  logic [3:0] lives_tmp;

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q     <= S_PLAY;
      lives_q     <= LIVES_INIT[2:0];
      frame_cnt_q <= 8'd0;
    end else begin
      state_q     <= state_d;
      lives_q     <= lives_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    death      = 1'b0;
    frame_last = 1'b0;

    case (state_q)
      S_PLAY: begin
        death = (bumpy_state == DIE_CODE);
        if (death) state_d = S_DYING;
      end
      S_DYING: begin
        frame_last = startOfFrame && (frame_cnt_q == DIE_LAST);
        if (frame_last) state_d = (lives_q == 3'd0) ? S_GAMEOVER : S_RESPAWN;
      end
      S_RESPAWN: begin
        state_d = S_INVULN;
      end
      S_INVULN: begin
        frame_last = startOfFrame && (frame_cnt_q == INVULN_LAST);
        if (frame_last) state_d = S_PLAY;
      end
      S_GAMEOVER: begin
        if (new_game) state_d = S_RESPAWN;
      end
      default: begin
        state_d = S_PLAY;
      end
    endcase
  end

  // Bonus is applied before the death decrement so a coincident pair nets to
  // zero, except at the ceiling where the bonus is lost to saturation.
  always_comb begin
    lives_tmp = {1'b0, lives_q};
    if (state_q == S_GAMEOVER) begin
      if (new_game) lives_tmp = LIVES_INIT;
    end else if (add_life && (lives_tmp < LIVES_MAX)) begin
      lives_tmp = lives_tmp + 4'd1;
    end
    if (death && (lives_tmp != 4'd0)) lives_tmp = lives_tmp - 4'd1;
    lives_d = lives_tmp[2:0];
  end

  // A tick that coincides with a state change is dropped: the new state starts at 0.
  always_comb begin
    frame_cnt_d = frame_cnt_q;
    if (state_d != state_q) begin
      frame_cnt_d = 8'd0;
    end else if (startOfFrame && ((state_q == S_DYING) || (state_q == S_INVULN))) begin
      frame_cnt_d = frame_cnt_q + 8'd1;
    end
  end

  always_comb begin
    lives            = lives_q;
    ctrl_state       = state_q;
    game_over        = (state_q == S_GAMEOVER);
    respawn_pulse    = (state_q == S_RESPAWN);
    bumpy_fsm_resetN = !((state_q == S_RESPAWN) || (state_q == S_GAMEOVER));
    blink            = 1'b0;
    if ((state_q == S_DYING) || (state_q == S_INVULN)) blink = frame_cnt_q[BLINK_SHIFT];
  end

endmodule

// File: tb/tb_bumpy_life_ctrl.sv
// Bench for bumpy_life_ctrl: fixed vector table, directed corner sequences and a
// randomized run compared against a frame-level reference model.
module tb_bumpy_life_ctrl;

  localparam int DIE_F = 4;
  localparam int INV_F = 6;
  localparam int BSH   = 0;
  localparam int INIT  = 3;
  localparam int MAXL  = 7;
  localparam int DCODE = 6;

  logic       clk = 1'b0;
  logic       resetN = 1'b0;
  logic       startOfFrame = 1'b0;
  logic [3:0] bumpy_state = 4'd0;
  logic       add_life = 1'b0;
  logic       new_game = 1'b0;
  logic [2:0] lives;
  logic       bumpy_fsm_resetN;
  logic       respawn_pulse;
  logic       blink;
  logic       game_over;
  logic [2:0] ctrl_state;

  bumpy_life_ctrl #(
    .INIT_LIVES(INIT), .MAX_LIVES(MAXL), .DIE_CODE(4'd6),
    .DIE_FRAMES(DIE_F), .INVULN_FRAMES(INV_F), .BLINK_SHIFT(BSH)
  ) dut (
    .clk(clk), .resetN(resetN), .startOfFrame(startOfFrame),
    .bumpy_state(bumpy_state), .add_life(add_life), .new_game(new_game),
    .lives(lives), .bumpy_fsm_resetN(bumpy_fsm_resetN),
    .respawn_pulse(respawn_pulse), .blink(blink), .game_over(game_over),
    .ctrl_state(ctrl_state)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: phase 0 play, 1 dying, 2 respawn, 3 invuln, 4 game over.
  int m_phase, m_lives, m_frames;

  task automatic model_reset();
    m_phase = 0; m_lives = INIT; m_frames = 0;
  endtask

  task automatic model_step(input bit sof, input int bs, input bit al, input bit ng);
    int np, nl;
    bit died;
    np   = m_phase;
    nl   = m_lives;
    died = (m_phase == 0) && (bs == DCODE);
    if (m_phase == 4) begin
      if (ng) begin nl = INIT; np = 2; end
    end else if (al) begin
      nl = (nl + 1 > MAXL) ? MAXL : nl + 1;
    end
    if (died) begin
      nl = (nl > 0) ? nl - 1 : 0;
      np = 1;
    end
    if (m_phase == 1 && sof && (m_frames + 1 == DIE_F)) np = (m_lives == 0) ? 4 : 2;
    if (m_phase == 2) np = 3;
    if (m_phase == 3 && sof && (m_frames + 1 == INV_F)) np = 0;
    if (np != m_phase) m_frames = 0;
    else if (sof && (m_phase == 1 || m_phase == 3)) m_frames++;
    m_phase = np;
    m_lives = nl;
  endtask

  function automatic logic [9:0] model_out();
    logic [2:0] st, lv;
    logic rn, rp, bl, go;
    st = 3'(m_phase);
    lv = 3'(m_lives);
    rn = !(m_phase == 2 || m_phase == 4);
    rp = (m_phase == 2);
    go = (m_phase == 4);
    bl = (m_phase == 1 || m_phase == 3) ? 1'((m_frames >> BSH) & 1) : 1'b0;
    return {st, lv, rn, rp, bl, go};
  endfunction

  function automatic logic [9:0] dut_out();
    return {ctrl_state, lives, bumpy_fsm_resetN, respawn_pulse, blink, game_over};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick(input string name);
    @(posedge clk);
    model_step(startOfFrame, int'(bumpy_state), add_life, new_game);
    #1;
    check(name, 32'(dut_out()), 32'(model_out()));
  endtask

  task automatic drive(input bit sof, input int bs, input bit al, input bit ng);
    startOfFrame = sof; bumpy_state = 4'(bs); add_life = al; new_game = ng;
  endtask

  task automatic run_until(input int target, input int budget, input string name);
    bit hit;
    hit = 0;
    drive(1, 0, 0, 0);
    for (int i = 0; i < budget && !hit; i++) begin
      tick(name);
      if (int'(ctrl_state) == target) hit = 1;
    end
    check({name, "_reached"}, 32'(hit), 32'd1);
  endtask

  typedef struct {
    logic sof; logic [3:0] bs; logic al; logic ng;
    logic [2:0] st; logic [2:0] lv; logic rn; logic rp; logic bl; logic go;
  } vec_t;

  vec_t vecs[16];

  initial begin
    // rows: sof bs al ng | state lives rstN resp blink go
    vecs[0]  = '{1'b0, 4'd6, 1'b0, 1'b0, 3'd1, 3'd2, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[1]  = '{1'b1, 4'd0, 1'b0, 1'b0, 3'd1, 3'd2, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[2]  = '{1'b1, 4'd0, 1'b0, 1'b0, 3'd1, 3'd2, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[3]  = '{1'b1, 4'd0, 1'b0, 1'b0, 3'd1, 3'd2, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[4]  = '{1'b1, 4'd0, 1'b0, 1'b0, 3'd2, 3'd2, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[5]  = '{1'b1, 4'd0, 1'b0, 1'b0, 3'd3, 3'd2, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[6]  = '{1'b1, 4'd6, 1'b0, 1'b0, 3'd3, 3'd2, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[7]  = '{1'b1, 4'd6, 1'b0, 1'b0, 3'd3, 3'd2, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[8]  = '{1'b1, 4'd6, 1'b0, 1'b0, 3'd3, 3'd2, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[9]  = '{1'b1, 4'd6, 1'b0, 1'b0, 3'd3, 3'd2, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[10] = '{1'b1, 4'd6, 1'b0, 1'b0, 3'd3, 3'd2, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[11] = '{1'b1, 4'd6, 1'b0, 1'b0, 3'd0, 3'd2, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[12] = '{1'b0, 4'd0, 1'b0, 1'b0, 3'd0, 3'd2, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[13] = '{1'b0, 4'd0, 1'b1, 1'b0, 3'd0, 3'd3, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[14] = '{1'b0, 4'd6, 1'b1, 1'b0, 3'd1, 3'd3, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[15] = '{1'b1, 4'd0, 1'b0, 1'b1, 3'd1, 3'd3, 1'b1, 1'b0, 1'b1, 1'b0};

    model_reset();
    #12;
    check("reset_outputs", 32'(dut_out()), 32'({3'd0, 3'd3, 1'b1, 1'b0, 1'b0, 1'b0}));
    @(negedge clk);
    resetN = 1'b1;

    drive(1, 1, 0, 0);
    for (int i = 0; i < 10; i++) tick("idle_play");
    check("idle_state", 32'(dut_out()), 32'({3'd0, 3'd3, 1'b1, 1'b0, 1'b0, 1'b0}));

    for (int i = 0; i < 16; i++) begin
      drive(vecs[i].sof, int'(vecs[i].bs), vecs[i].al, vecs[i].ng);
      tick("vec_model");
      check($sformatf("vec_%0d", i), 32'(dut_out()),
            32'({vecs[i].st, vecs[i].lv, vecs[i].rn, vecs[i].rp, vecs[i].bl, vecs[i].go}));
    end

    run_until(0, 40, "recover_from_vec");

    for (int d = 0; d < 3; d++) begin
      drive(0, 6, 0, 0);
      tick("death_enter");
      check("death_state", 32'(ctrl_state), 32'd1);
      if (d < 2) run_until(0, 40, "death_recover");
      else run_until(4, 40, "death_gameover");
    end
    check("gameover_outputs", 32'(dut_out()), 32'({3'd4, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1}));
    drive(1, 6, 1, 0);
    for (int i = 0; i < 3; i++) tick("gameover_hold");
    check("gameover_add_ignored", 32'(lives), 32'd0);
    check("gameover_frozen", 32'(bumpy_fsm_resetN), 32'd0);
    drive(0, 0, 0, 1);
    tick("new_game");
    check("new_game_respawn", 32'(dut_out()), 32'({3'd2, 3'd3, 1'b0, 1'b1, 1'b0, 1'b0}));
    drive(0, 0, 0, 0);
    tick("after_respawn");
    check("after_respawn_invuln", 32'(ctrl_state), 32'd3);
    run_until(0, 40, "invuln_to_play");

    drive(0, 0, 1, 0);
    for (int i = 0; i < 6; i++) tick("add_life");
    check("lives_saturated", 32'(lives), 32'(MAXL));
    drive(0, 6, 1, 0);
    tick("add_with_death");
    check("add_death_at_max", 32'(lives), 32'(MAXL - 1));

    drive(1, 0, 0, 0);
    tick("dying_f1");
    tick("dying_f2");
    #2 resetN = 1'b0;
    model_reset();
    #1;
    check("async_reset", 32'(dut_out()), 32'({3'd0, 3'd3, 1'b1, 1'b0, 1'b0, 1'b0}));
    @(negedge clk);
    resetN = 1'b1;
    drive(0, 0, 0, 0);
    for (int i = 0; i < 6; i++) begin
      tick("post_reset");
      check("post_reset_no_pulse", 32'(respawn_pulse), 32'd0);
    end

    for (int i = 0; i < 3000; i++) begin
      drive($urandom_range(0, 1) == 0,
            ($urandom_range(0, 5) == 0) ? DCODE : int'($urandom_range(0, 15)),
            $urandom_range(0, 11) == 0,
            $urandom_range(0, 9) == 0);
      tick("random");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, got timeout, required completion");
    $fatal(1, "watchdog");
  end

endmodule
